exec_stage_mc: RTL and testbench

Parametrised execute stage with an EX/MEM output register, stall and flush handling, and an iterative multi-cycle multiplier. It sits between the decode/register-read stage and the memory stage. It resolves ALU results, branch/jump targets and branch decisions in one cycle. MUL occupies the stage for WIDTH+1 cycles and back-pressures upstream through `ready`.

---
 rtl/exec_stage_mc.sv | 221 ++++++++++++++++++++++
 tb/tb_exec_stage_mc.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage_mc.sv
// Execute stage: single-cycle ALU/branch resolution into an EX/MEM register,
// plus a shift-add multiplier that occupies the stage for WIDTH+1 cycles.
module exec_stage_mc #(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                ready,
  input  logic [2:0]          op,
  input  logic [WIDTH-1:0]    opA,
  input  logic [WIDTH-1:0]    opB,
  input  logic [2:0]          br_type,
  input  logic                jr_sel,
  input  logic [WIDTH-1:0]    pc_next,
  input  logic [WIDTH-1:0]    offset,
  input  logic [REG_BITS-1:0] dest,
  input  logic                reg_wrt,
  input  logic                stall_in,
  input  logic                flush,
  output logic                out_valid,
  output logic [WIDTH-1:0]    result,
  output logic                do_branch,
  output logic [WIDTH-1:0]    branch_pc,
  output logic [REG_BITS-1:0] dest_out,
  output logic                reg_wrt_out,
  output logic                err
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic [SHW-1:0]      cnt_q, cnt_d;
  logic [REG_BITS-1:0] mdest_q, mdest_d;
  logic                mwrt_q, mwrt_d;
  logic                merr_q, merr_d;

  logic                valid_q, valid_d;
  logic [WIDTH-1:0]    res_q, res_d;
  logic                br_q, br_d;
  logic [WIDTH-1:0]    bpc_q, bpc_d;
  logic [REG_BITS-1:0] dst_q, dst_d;
  logic                wrt_q, wrt_d;
  logic                err_q, err_d;

  logic             accept;
  logic             is_mul;
  logic             op_ill;
  logic             br_ill;
  logic             cond;
  logic             instr_err;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] target;

  assign ready  = (state_q == S_IDLE) & ~stall_in & ~flush;
  assign accept = in_valid & ready;
  assign is_mul = (op == OP_MUL);
  assign br_ill = (br_type > 3'd5);
  assign target = (jr_sel ? opA : pc_next) + offset;
  assign instr_err = op_ill | br_ill | (is_mul & (br_type != 3'd0));

  always_comb begin
    alu_res = '0;
    op_ill  = 1'b0;
    case (op)
      OP_ADD:  alu_res = opA + opB;
      OP_SUB:  alu_res = opA - opB;
      OP_AND:  alu_res = opA & opB;
      OP_XOR:  alu_res = opA ^ opB;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(opA) < $signed(opB)};
      OP_SHL:  alu_res = opA << opB[SHW-1:0];
      OP_MUL:  alu_res = '0;
      default: op_ill  = 1'b1;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    case (br_type)
      3'd1:    cond = (opA == '0);
      3'd2:    cond = (opA != '0);
      3'd3:    cond = opA[WIDTH-1];
      3'd4:    cond = ~opA[WIDTH-1];
      3'd5:    cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  // Next state: flush abandons any multiply in progress.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (accept && is_mul) state_d = S_MUL;
        S_MUL:   if (cnt_q == CNT_LAST) state_d = S_DONE;
        S_DONE:  if (!stall_in) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mdest_d  = mdest_q;
    mwrt_d   = mwrt_q;
    merr_d   = merr_q;
    if (state_q == S_IDLE && accept && is_mul) begin
      mcand_d  = opA;
      mplier_d = opB;
      acc_d    = '0;
      cnt_d    = '0;
      mdest_d  = dest;
      mwrt_d   = reg_wrt;
      merr_d   = instr_err;
    end else if (state_q == S_MUL) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  // Output register: bubble unless holding, retiring a product or loading an ALU op.
  always_comb begin
    valid_d = 1'b0;
    res_d   = '0;
    br_d    = 1'b0;
    bpc_d   = '0;
    dst_d   = '0;
    wrt_d   = 1'b0;
    err_d   = 1'b0;
    if (!flush && stall_in) begin
      valid_d = valid_q;
      res_d   = res_q;
      br_d    = br_q;
      bpc_d   = bpc_q;
      dst_d   = dst_q;
      wrt_d   = wrt_q;
      err_d   = err_q;
    end else if (!flush && state_q == S_DONE) begin
      valid_d = 1'b1;
      res_d   = acc_q;
      dst_d   = mdest_q;
      wrt_d   = mwrt_q & ~merr_q;
      err_d   = merr_q;
    end else if (accept && !is_mul) begin
      valid_d = 1'b1;
      res_d   = alu_res;
      br_d    = cond & ~instr_err;
      bpc_d   = target;
      dst_d   = dest;
      wrt_d   = reg_wrt & ~instr_err;
      err_d   = instr_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mdest_q  <= '0;
      mwrt_q   <= 1'b0;
      merr_q   <= 1'b0;
      valid_q  <= 1'b0;
      res_q    <= '0;
      br_q     <= 1'b0;
      bpc_q    <= '0;
      dst_q    <= '0;
      wrt_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mdest_q  <= mdest_d;
      mwrt_q   <= mwrt_d;
      merr_q   <= merr_d;
      valid_q  <= valid_d;
      res_q    <= res_d;
      br_q     <= br_d;
      bpc_q    <= bpc_d;
      dst_q    <= dst_d;
      wrt_q    <= wrt_d;
      err_q    <= err_d;
    end
  end

  assign out_valid   = valid_q;
  assign result      = res_q;
  assign do_branch   = br_q;
  assign branch_pc   = bpc_q;
  assign dest_out    = dst_q;
  assign reg_wrt_out = wrt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_exec_stage_mc.sv
// Scoreboard bench for exec_stage_mc: directed cases then random traffic,
// checked against a plain-arithmetic reference model.
module tb_exec_stage_mc;
  localparam int W  = 16;
  localparam int RB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, ready, jr_sel, reg_wrt, stall_in, flush;
  logic          out_valid, do_branch, reg_wrt_out, err;
  logic [2:0]    op, br_type;
  logic [W-1:0]  opA, opB, pc_next, offset, result, branch_pc;
  logic [RB-1:0] dest, dest_out;

  exec_stage_mc #(.WIDTH(W), .REG_BITS(RB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ready(ready), .op(op),
    .opA(opA), .opB(opB), .br_type(br_type), .jr_sel(jr_sel),
    .pc_next(pc_next), .offset(offset), .dest(dest), .reg_wrt(reg_wrt),
    .stall_in(stall_in), .flush(flush), .out_valid(out_valid),
    .result(result), .do_branch(do_branch), .branch_pc(branch_pc),
    .dest_out(dest_out), .reg_wrt_out(reg_wrt_out), .err(err)
  );

  typedef struct {
    logic [2:0]    op;
    logic [W-1:0]  a, b;
    logic [2:0]    br;
    logic          jr;
    logic [W-1:0]  pc, off;
    logic [RB-1:0] dst;
    logic          wrt;
  } instr_t;

  typedef struct {
    logic          valid;
    logic [W-1:0]  res;
    logic          br;
    logic [W-1:0]  bpc;
    logic [RB-1:0] dst;
    logic          wrt;
    logic          err;
  } out_t;

  out_t   sb[$];
  out_t   shown, mul_pend;
  int     n_cmp = 0;
  int     n_bad = 0;
  int     n_txn = 0;
  int     mul_iter = 0;
  bit     mul_done = 0;
  logic   last_ready;
  bit     held;
  instr_t idle;

  function automatic instr_t mk(input int o, input int a, input int b, input int br,
                                input int jr, input int pc, input int off,
                                input int d, input int w);
    instr_t i;
    i.op = 3'(o); i.a = W'(a); i.b = W'(b); i.br = 3'(br); i.jr = 1'(jr);
    i.pc = W'(pc); i.off = W'(off); i.dst = RB'(d); i.wrt = 1'(w);
    return i;
  endfunction

  function automatic out_t bubble_o();
    out_t o;
    o.valid = 1'b0; o.res = '0; o.br = 1'b0; o.bpc = '0;
    o.dst = '0; o.wrt = 1'b0; o.err = 1'b0;
    return o;
  endfunction

  // What the stage should eventually present for an accepted instruction.
  function automatic out_t ref_model(input instr_t i);
    out_t o;
    bit   ill_op, ill_br, take;
    int   sh;
    ill_op  = (i.op == 3'd7);
    ill_br  = (i.br > 3'd5);
    sh      = int'(i.b) % W;
    o.valid = 1'b1;
    o.dst   = i.dst;
    o.err   = ill_op || ill_br || (i.op == 3'd6 && i.br != 3'd0);
    case (i.op)
      3'd0:    o.res = i.a + i.b;
      3'd1:    o.res = i.a - i.b;
      3'd2:    o.res = i.a & i.b;
      3'd3:    o.res = i.a ^ i.b;
      3'd4:    o.res = ($signed(i.a) < $signed(i.b)) ? W'(1) : W'(0);
      3'd5:    o.res = i.a << sh;
      3'd6:    o.res = i.a * i.b;
      default: o.res = '0;
    endcase
    case (i.br)
      3'd1:    take = (i.a == 0);
      3'd2:    take = (i.a != 0);
      3'd3:    take = ($signed(i.a) < 0);
      3'd4:    take = ($signed(i.a) >= 0);
      3'd5:    take = 1'b1;
      default: take = 1'b0;
    endcase
    o.br  = take && !o.err && (i.op != 3'd6);
    o.bpc = (i.op == 3'd6) ? '0 : (i.jr ? i.a : i.pc) + i.off;
    o.wrt = i.wrt && !o.err;
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input out_t e);
    n_cmp++;
    if (out_valid !== e.valid || result !== e.res || do_branch !== e.br ||
        branch_pc !== e.bpc || dest_out !== e.dst || reg_wrt_out !== e.wrt ||
        err !== e.err) begin
      n_bad++;
      $display("FAIL %s @%0t: got v=%b res=%h br=%b pc=%h d=%0d w=%b e=%b, want v=%b res=%h br=%b pc=%h d=%0d w=%b e=%b",
               tag, $time, out_valid, result, do_branch, branch_pc, dest_out, reg_wrt_out, err,
               e.valid, e.res, e.br, e.bpc, e.dst, e.wrt, e.err);
    end
  endtask

  // One clock: drive after negedge, check ready, update the model at posedge.
  task automatic cycle(input bit v, input instr_t i, input bit st, input bit fl, input bit rs);
    bit   busy, exp_ready;
    out_t e;
    in_valid = v; op = i.op; opA = i.a; opB = i.b; br_type = i.br; jr_sel = i.jr;
    pc_next = i.pc; offset = i.off; dest = i.dst; reg_wrt = i.wrt;
    stall_in = st; flush = fl; rst = rs;
    #1;
    busy       = (mul_iter > 0) || mul_done;
    exp_ready  = !busy && !st && !fl;
    last_ready = ready;
    if (!rs) chk("ready", int'(ready), int'(exp_ready));
    @(posedge clk);
    if (rs || fl) begin
      mul_iter = 0;
      mul_done = 0;
    end else begin
      if (mul_done && !st) begin
        sb.push_back(mul_pend);
        mul_done = 0;
      end else if (mul_iter > 0) begin
        mul_iter--;
        if (mul_iter == 0) mul_done = 1;
      end
      if (v && exp_ready) begin
        e = ref_model(i);
        if (i.op == 3'd6) begin
          mul_iter = W;
          mul_pend = e;
        end else begin
          sb.push_back(e);
        end
      end
    end
    @(negedge clk);
  endtask

  function automatic int rnd_w();
    case ($urandom % 6)
      0:       return 0;
      1:       return 'h8000;
      2:       return 'hFFFF;
      3:       return 'h7FFF;
      default: return int'($urandom % 'h10000);
    endcase
  endfunction

  // Monitor: a loading edge with out_valid pops the scoreboard; a held edge
  // must repeat the last presented value; otherwise a bubble is required.
  initial begin : monitor
    out_t e;
    shown = bubble_o();
    forever begin
      @(posedge clk);
      held = (stall_in === 1'b1) && (flush !== 1'b1) && (rst !== 1'b1);
      @(negedge clk);
      if (held) begin
        check_out("hold", shown);
      end else if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output @%0t: got out_valid=1 res=%h, want no output", $time, result);
        end else begin
          e = sb.pop_front();
          check_out("txn", e);
          shown = e;
          n_txn++;
          $display("txn %0d @%0t res=%h br=%b pc=%h dest=%0d wrt=%b err=%b",
                   n_txn, $time, e.res, e.br, e.bpc, e.dst, e.wrt, e.err);
        end
      end else begin
        check_out("bubble", bubble_o());
        shown = bubble_o();
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: time limit reached, want bench to finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n_low, n_vld;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    cycle(0, idle, 0, 0, 1);
    cycle(0, idle, 0, 0, 1);
    cycle(0, idle, 0, 0, 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_ready", int'(last_ready), 1);

    cycle(1, mk(0, 'h1234, 'h0011, 0, 0, 0, 0, 3, 1), 0, 0, 0);
    chk("add_result", int'(result), 'h1245);
    chk("add_dest", int'(dest_out), 3);
    chk("add_err", int'(err), 0);

    cycle(1, mk(6, 3, 5, 0, 0, 0, 0, 2, 1), 0, 0, 0);
    n_low = 0;
    for (int k = 0; k < W + 1; k++) begin
      cycle(0, idle, 0, 0, 0);
      if (last_ready === 1'b0) n_low++;
    end
    chk("mul_ready_low", n_low, W + 1);
    chk("mul_valid", int'(out_valid), 1);
    chk("mul_3x5", int'(result), 'h000F);

    cycle(1, mk(6, 'hFFFF, 2, 0, 0, 0, 0, 5, 1), 0, 0, 0);
    for (int k = 0; k < W + 1; k++) cycle(0, idle, 0, 0, 0);
    chk("mul_ffff_x2", int'(result), 'hFFFE);

    cycle(1, mk(0, 0, 0, 1, 0, 'h0100, 'hFFFC, 1, 0), 0, 0, 0);
    chk("eqz_taken", int'(do_branch), 1);
    chk("eqz_pc", int'(branch_pc), 'h00FC);
    cycle(1, mk(0, 0, 0, 2, 0, 'h0100, 'hFFFC, 1, 0), 0, 0, 0);
    chk("nez_taken", int'(do_branch), 0);
    cycle(1, mk(0, 'h2000, 0, 5, 1, 'h0100, 'h0004, 1, 0), 0, 0, 0);
    chk("jmp_pc", int'(branch_pc), 'h2004);
    chk("jmp_taken", int'(do_branch), 1);

    cycle(1, mk(6, 7, 9, 0, 0, 0, 0, 4, 1), 0, 0, 0);
    for (int k = 0; k < 4; k++) cycle(0, idle, 0, 0, 0);
    cycle(0, idle, 0, 1, 0);
    chk("flush_valid", int'(out_valid), 0);
    cycle(0, idle, 0, 0, 0);
    chk("flush_ready", int'(last_ready), 1);
    n_vld = 0;
    for (int k = 0; k < W + 4; k++) begin
      cycle(0, idle, 0, 0, 0);
      if (out_valid === 1'b1) n_vld++;
    end
    chk("flush_no_result", n_vld, 0);

    cycle(1, mk(6, 3, 5, 0, 0, 0, 0, 6, 1), 0, 0, 0);
    for (int k = 1; k <= 25; k++) cycle(0, idle, (k >= 10), 0, 0);
    chk("stall_done_valid", int'(out_valid), 0);
    cycle(0, idle, 0, 0, 0);
    chk("stall_mul_result", int'(result), 'h000F);
    chk("stall_mul_valid", int'(out_valid), 1);

    cycle(1, mk(3, 'h00FF, 'h0F0F, 0, 0, 0, 0, 2, 1), 0, 0, 0);
    cycle(0, idle, 1, 0, 0);
    cycle(0, idle, 1, 0, 0);
    chk("stall_alu_hold", int'(result), 'h0FF0);
    cycle(0, idle, 0, 0, 0);

    cycle(1, mk(7, 5, 6, 0, 0, 0, 0, 7, 1), 0, 0, 0);
    chk("illop_err", int'(err), 1);
    chk("illop_wrt", int'(reg_wrt_out), 0);
    chk("illop_result", int'(result), 0);
    cycle(1, mk(0, 0, 1, 6, 0, 0, 0, 1, 1), 0, 0, 0);
    chk("illbr_err", int'(err), 1);
    chk("illbr_branch", int'(do_branch), 0);

    cycle(1, mk(6, 11, 13, 0, 0, 0, 0, 3, 1), 0, 0, 0);
    for (int k = 0; k < 5; k++) cycle(0, idle, 0, 0, 0);
    cycle(0, idle, 0, 0, 1);
    chk("rst_mid_valid", int'(out_valid), 0);
    chk("rst_mid_result", int'(result), 0);
    cycle(0, idle, 0, 0, 0);
    chk("rst_mid_ready", int'(last_ready), 1);

    for (int k = 0; k < 600; k++) begin
      instr_t ri;
      ri = mk(int'($urandom % 8), rnd_w(), rnd_w(), int'($urandom % 8), int'($urandom % 2),
              rnd_w(), rnd_w(), int'($urandom % 8), int'($urandom % 2));
      cycle(($urandom % 4) != 0, ri, ($urandom % 8) == 0, ($urandom % 40) == 0, 0);
    end

    for (int k = 0; k < W + 6; k++) cycle(0, idle, 0, 0, 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
